// File: rtl/uart_tx_buffer.sv
// 8N1 UART transmitter with a one-letter holding register in front of the
// shift register, so a second letter can be queued while a frame is on the line.
module uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] guess_in,
  input  logic       send,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic             hold_valid, hold_valid_next;
  logic [7:0]       hold_data;
  logic [7:0]       shift;
  logic             accept;
  logic             load;
  logic             bit_end;
  logic             serial_next;

  always_comb begin
    accept          = send && !hold_valid;
    bit_end         = (cnt == CNT_MAX);
    state_next      = state;
    cnt_next        = cnt + CNT_W'(1);
    idx_next        = idx;
    load            = 1'b0;
    serial_next     = 1'b1;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (hold_valid) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx == 3'd7) state_next = STOP;
          else             idx_next   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          // A queued letter starts its frame immediately, with no idle gap.
          if (hold_valid) begin
            load       = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // accept and load never coincide: accept needs hold_valid=0, load needs 1.
    hold_valid_next = load ? 1'b0 : (accept ? 1'b1 : hold_valid);

    // Line level is registered, so it is derived from the upcoming state.
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift[idx_next];
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      hold_valid <= 1'b0;
      tx_serial  <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      hold_valid <= hold_valid_next;
      tx_serial  <= serial_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) hold_data <= guess_in;
    if (load)   shift     <= hold_data;
  end

  assign tx_ready = !hold_valid;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer at CLKS_PER_BIT=4: reset, single frame,
// back-to-back frames with an ignored overflow send, and reset mid-frame.
module tb_uart_tx_buffer;

  localparam int CPB = 4;
  localparam int NONE = 1000;

  logic       clk;
  logic       rst;
  logic [7:0] guess_in;
  logic       send;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int checks;
  int errors;

  uart_tx_buffer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .guess_in  (guess_in),
    .send      (send),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a letter from IDLE for one edge; the cycle after the accept the
  // line is still idle and the holding register is full.
  task automatic send_idle(input logic [7:0] b);
    @(negedge clk);
    guess_in = b;
    send     = 1'b1;
    @(negedge clk);
    check("accept_ready", tx_ready, 0);
    check("accept_serial", tx_serial, 1);
    check("accept_busy", tx_busy, 0);
    send     = 1'b0;
    guess_in = ~b;
  endtask

  // Walk one 40-cycle frame, optionally presenting two more letters mid-frame.
  task automatic expect_frame(input logic [7:0] b, input int i1, input logic [7:0] b1,
                              input int i2, input logic [7:0] b2);
    int  bitn;
    logic e;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      bitn = k / CPB;
      if (bitn == 0)      e = 1'b0;
      else if (bitn == 9) e = 1'b1;
      else                e = b[bitn-1];
      check($sformatf("serial_%0h_c%0d", b, k), tx_serial, e);
      check($sformatf("busy_%0h_c%0d", b, k), tx_busy, 1);
      check($sformatf("done_%0h_c%0d", b, k), tx_done, (k == 10 * CPB - 1));
      if (k == 0) check($sformatf("ready_start_%0h", b), tx_ready, 1);
      if (k == i1 + 1 || k == i2 + 1) begin
        check($sformatf("ready_held_%0h_c%0d", b, k), tx_ready, 0);
        send     = 1'b0;
        guess_in = 8'hFF ^ guess_in;
      end
      if (k == i1) begin guess_in = b1; send = 1'b1; end
      if (k == i2) begin guess_in = b2; send = 1'b1; end
    end
  endtask

  task automatic expect_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("idle_serial_c%0d", k), tx_serial, 1);
      check($sformatf("idle_busy_c%0d", k), tx_busy, 0);
      check($sformatf("idle_done_c%0d", k), tx_done, 0);
      check($sformatf("idle_ready_c%0d", k), tx_ready, 1);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    send     = 1'b0;
    guess_in = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    rst = 1'b0;
    expect_idle(2);

    // Single letter 0x41
    send_idle(8'h41);
    expect_frame(8'h41, NONE, 8'h00, NONE, 8'h00);
    expect_idle(3);

    // Back-to-back 0x41/0x42, with 0x43 presented while 0x42 is held
    send_idle(8'h41);
    expect_frame(8'h41, 5, 8'h42, 12, 8'h43);
    expect_frame(8'h42, NONE, 8'h00, NONE, 8'h00);
    expect_idle(45);

    // Reset during data bit 3, with 0x42 held at the time
    send_idle(8'h41);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 3) begin send = 1'b0; guess_in = 8'h00; end
      if (k == 2) begin guess_in = 8'h42; send = 1'b1; end
    end
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_ready", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_serial", tx_serial, 1);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_done", tx_done, 0);
    rst = 1'b0;
    expect_idle(50);

    // Recovery with 0x5A
    send_idle(8'h5A);
    expect_frame(8'h5A, NONE, 8'h00, NONE, 8'h00);
    expect_idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clk cycles per serial bit period; legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 guess_in  input  8  ASCII letter to transmit.
REQ-005 send  input  1  request; letter accepted on an edge where send=1 and tx_ready=1.
REQ-006 tx_ready  output  1  holding register empty; a new letter may be accepted.
REQ-007 tx_serial  output  1  UART line, 8N1, LSB first, idle high; registered.
REQ-008 tx_busy  output  1  high while a frame is on the line (START/DATA/STOP).
REQ-009 tx_done  output  1  one-cycle pulse on completion of each stop bit.

Function
REQ-010 Storage SHALL be two-deep: one holding register (hold_data, hold_valid) plus one shift register owned by the FSM.
REQ-011 tx_ready SHALL equal !hold_valid, combinationally.
REQ-012 On an accepting edge, hold_data SHALL capture guess_in and hold_valid SHALL set.
REQ-013 send while tx_ready=0 SHALL be ignored; hold_data is unchanged and no error is flagged.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: tx_serial=1; if hold_valid, next edge loads shift register from hold_data, clears hold_valid, enters START.
REQ-016 START: tx_serial=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: tx_serial = shift bit[index] for CLKS_PER_BIT cycles per bit; index 0..7; after bit 7, enter STOP.
REQ-018 STOP: tx_serial=1 for CLKS_PER_BIT cycles; on the final cycle assert tx_done for that one cycle.
REQ-019 Leaving STOP with hold_valid=1 SHALL go directly to START (loading as in REQ-015), with no idle cycle between frames; otherwise go to IDLE.
REQ-020 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-021 Latency: letter accepted at edge N from IDLE -> tx_serial low from edge N+1; tx_ready high again after edge N+1.
REQ-022 Baud counter SHALL be wide enough for CLKS_PER_BIT-1, reset to 0 on every state/bit change, and never wrap mid-bit.
REQ-023 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-024 Changes on guess_in after acceptance SHALL NOT affect the frame in progress or the held letter.
REQ-025 An accept and a hold-to-shift load SHALL never coincide, because tx_ready=0 whenever hold_valid=1.

Reset
REQ-026 With rst=1 at an edge, the next state SHALL be: state IDLE, hold_valid=0, counters 0, tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1.
REQ-027 rst SHALL take priority over send and over all FSM activity.
REQ-028 Reset mid-frame SHALL abandon the frame: the line goes high on the next cycle, no tx_done is produced, and the held letter is discarded.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Reset: rst=1 for 2 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
REQ-030 Single letter: send 0x41 one cycle -> line 0,1,0,0,0,0,0,1,0,1, each held 4 cycles; tx_done a single pulse at cycle 40 of the frame; then IDLE.
REQ-031 Back-to-back: send 0x41, then 0x42 while busy -> 0x42 accepted (tx_ready drops), frames contiguous with no idle gap, 80 cycles total, two tx_done pulses.
REQ-032 Overflow: 0x41 transmitting, 0x42 held, send 0x43 -> ignored; only 0x41 and 0x42 appear on the line.
REQ-033 Reset mid-DATA (during bit 3) -> tx_serial=1 next cycle, tx_ready=1, no tx_done; a following send 0x5A transmits correctly.
REQ-034 Loopback, CLKS_PER_BIT=1250: tx_serial drives buffRX rx_serial with rec_ready=1; send 0x41 -> buffRX guess=0x41, err_LED=0.
